// File: rtl/spm_sequencer.sv
// spm_sequencer
//   Control sequencer for a signed serial-parallel multiplier (SPM) cell array.
//   An accepted start request latches both operands, clears the SPM array for one
//   cycle, streams the multiplier LSB-first (sign-extended) for PROD_W cycles while
//   shifting the serial product in, then flags the finished product.
//
// Ports
//   clk            system clock, all state on rising edge
//   rst            asynchronous active-low reset
//   start          one-cycle request pulse, only honoured in IDLE
//   multiplicand   operand Y, captured on accept
//   multiplier     operand X, captured on accept
//   spm_load       one-cycle clear of SPM accumulators/carries
//   spm_shift_en   SPM advances one bit this cycle
//   spm_x_bit      serial multiplier bit for this cycle
//   spm_y          latched multiplicand, stable until the next accept
//   spm_p_bit      serial product bit from the SPM, valid while spm_shift_en=1
//   busy           high in LOAD and SHIFT
//   done           one-cycle pulse when the product becomes valid
//   product_valid  level, set with done, cleared on the next accept
//   product        signed result, held until the next accept
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; product/product_valid hold last result
// S_LOAD  | one-cycle clear of the SPM array, bit counter cleared
// S_SHIFT | PROD_W cycles streaming X bits out and product bits in
// S_DONE  | one-cycle done pulse, then back to idle

module spm_sequencer #(
  parameter int WIDTH  = 8,
  parameter int PROD_W = 2 * WIDTH,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  multiplicand,
  input  logic [WIDTH-1:0]  multiplier,
  output logic              spm_load,
  output logic              spm_shift_en,
  output logic              spm_x_bit,
  output logic [WIDTH-1:0]  spm_y,
  input  logic              spm_p_bit,
  output logic              busy,
  output logic              done,
  output logic              product_valid,
  output logic [PROD_W-1:0] product
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PROD_W - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] xreg;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             zero_op;
  logic             last_bit;

  // A zero operand makes the product trivially zero, so the SPM is skipped.
  assign zero_op  = (multiplier == '0) || (multiplicand == '0);
  assign last_bit = (cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    spm_load     = 1'b0;
    spm_shift_en = 1'b0;
    spm_x_bit    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = zero_op ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        spm_load  = 1'b1;
        busy      = 1'b1;
        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        spm_shift_en = 1'b1;
        spm_x_bit    = xreg[0];
        busy         = 1'b1;
        if (last_bit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xreg          <= '0;
      spm_y         <= '0;
      cnt           <= '0;
      product       <= '0;
      product_valid <= 1'b0;
    end else begin
      if (accept) begin
        xreg    <= multiplier;
        spm_y   <= multiplicand;
        product <= '0;
      end

      if (state == S_LOAD) begin
        cnt <= '0;
      end

      if (state == S_SHIFT) begin
        // Arithmetic shift: once the real bits are used up, the sign bit repeats.
        xreg    <= {xreg[WIDTH-1], xreg[WIDTH-1:1]};
        product <= {spm_p_bit, product[PROD_W-1:1]};
        if (!last_bit) begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      // Raised on entry to DONE so the level is already high alongside done;
      // this also wins over the clear on a fast-path accept.
      if (state_nxt == S_DONE) begin
        product_valid <= 1'b1;
      end else if (accept) begin
        product_valid <= 1'b0;
      end
    end
  end

endmodule
